// File: rtl/sr_puf_pkg.sv
// sr_puf_pkg: shared types and constants for the SR-latch PUF array.
// Holds the controller state encoding and the vote-counter width helper.
package sr_puf_pkg;

    typedef enum logic [2:0] {
        IDLE,
        EXCITE,
        SETTLE,
        SAMPLE,
        DONE
    } state_t;

    // Bits needed to count 0..n votes.
    function automatic int unsigned vote_width(input int unsigned n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/sr_puf_sync.sv
// sr_puf_sync: parametrised-width two-flop synchronizer for the raw
// asynchronous latch outputs. Asynchronous active-high reset clears both stages.
module sr_puf_sync #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;

    // Two back-to-back capture stages.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_meta <= '0;
            r_sync <= '0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/sr_puf_array.sv
// sr_puf_array: controller for an array of external SR-latch PUF cells.
// Each response is a per-cell majority vote over NUM_EVALS evaluations of
// excite -> settle -> sample. Optional macro SR_PUF_STABILITY_EN adds the
// registered 'unstable' output flagging cells whose votes were not unanimous.
module sr_puf_array
    import sr_puf_pkg::*;
#(
    parameter int unsigned NUM_CELLS     = 32,
    parameter int unsigned NUM_EVALS     = 5,
    parameter int unsigned EXCITE_CYCLES = 2,
    parameter int unsigned SETTLE_CYCLES = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    output logic                 excite,
    input  logic [NUM_CELLS-1:0] cell_out,
    output logic                 busy,
    output logic                 resp_valid,
    input  logic                 resp_ready,
    output logic [NUM_CELLS-1:0] response
`ifdef SR_PUF_STABILITY_EN
    ,
    output logic [NUM_CELLS-1:0] unstable
`endif
);

    localparam int unsigned VW    = vote_width(NUM_EVALS);
    localparam int unsigned PMAX  = (EXCITE_CYCLES > SETTLE_CYCLES) ? EXCITE_CYCLES : SETTLE_CYCLES;
    localparam int unsigned CW    = $clog2(PMAX + 1);

    localparam logic [CW-1:0] EXC_LAST = CW'(EXCITE_CYCLES - 1);
    localparam logic [CW-1:0] SET_LAST = CW'(SETTLE_CYCLES - 1);
    localparam logic [VW-1:0] EV_LAST  = VW'(NUM_EVALS - 1);
    localparam logic [VW-1:0] V_HALF   = VW'(NUM_EVALS / 2);

    state_t                r_state;
    state_t                w_next;
    logic [CW-1:0]         r_phase;
    logic [VW-1:0]         r_evals;
    logic [VW-1:0]         r_vote    [NUM_CELLS];
    logic [VW-1:0]         w_vote_nx [NUM_CELLS];
    logic [NUM_CELLS-1:0]  w_sync;
    logic [NUM_CELLS-1:0]  r_response;
    logic                  w_last_sample;

    sr_puf_sync #(
        .WIDTH (NUM_CELLS)
    ) u_sync (
        .i_clk (clk),
        .i_rst (rst),
        .i_d   (cell_out),
        .o_q   (w_sync)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic and state-decoded outputs.
    always_comb begin
        w_next     = r_state;
        excite     = 1'b0;
        busy       = 1'b1;
        resp_valid = 1'b0;
        case (r_state)
            IDLE: begin
                busy = 1'b0;
                if (start) w_next = EXCITE;
            end
            EXCITE: begin
                excite = 1'b1;
                if (r_phase == EXC_LAST) w_next = SETTLE;
            end
            SETTLE: begin
                if (r_phase == SET_LAST) w_next = SAMPLE;
            end
            SAMPLE: begin
                w_next = (r_evals == EV_LAST) ? DONE : EXCITE;
            end
            DONE: begin
                resp_valid = 1'b1;
                if (resp_ready) w_next = IDLE;
            end
            default: begin
                w_next = IDLE;
                busy   = 1'b0;
            end
        endcase
    end

    // Cycle counter within EXCITE/SETTLE; restarts on every state change.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_phase <= '0;
        end else if (w_next != r_state) begin
            r_phase <= '0;
        end else if (r_state == EXCITE || r_state == SETTLE) begin
            r_phase <= r_phase + 1'b1;
        end
    end

    // Vote totals including the current sample, used both for the counter
    // update and for the final majority so DONE entry sees all evaluations.
    always_comb begin
        for (int unsigned i = 0; i < NUM_CELLS; i++) begin
            w_vote_nx[i] = r_vote[i] + VW'(w_sync[i]);
        end
    end

    assign w_last_sample = (r_state == SAMPLE) && (r_evals == EV_LAST);

    // Vote/evaluation counters and the majority-voted response register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_evals    <= '0;
            r_response <= '0;
            for (int unsigned i = 0; i < NUM_CELLS; i++) r_vote[i] <= '0;
        end else if (r_state == IDLE && start) begin
            r_evals <= '0;
            for (int unsigned i = 0; i < NUM_CELLS; i++) r_vote[i] <= '0;
        end else if (r_state == SAMPLE) begin
            r_evals <= r_evals + 1'b1;
            for (int unsigned i = 0; i < NUM_CELLS; i++) begin
                r_vote[i] <= w_vote_nx[i];
                if (w_last_sample) r_response[i] <= (w_vote_nx[i] > V_HALF);
            end
        end
    end

    assign response = r_response;

`ifdef SR_PUF_STABILITY_EN
    localparam logic [VW-1:0] V_ALL = VW'(NUM_EVALS);
    logic [NUM_CELLS-1:0] r_unstable;

    // Non-unanimous cells, latched alongside the response.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_unstable <= '0;
        end else if (w_last_sample) begin
            for (int unsigned i = 0; i < NUM_CELLS; i++) begin
                r_unstable[i] <= (w_vote_nx[i] != '0) && (w_vote_nx[i] != V_ALL);
            end
        end
    end

    assign unstable = r_unstable;
`endif

endmodule
